motion_sequencer: RTL and testbench
===================================

# motion_sequencer

Command queue and sequencer placed in front of the motion datapath (`Motion_Commands`). It accepts 10-bit motion commands with a 3-bit speed from the top-level controller into a small FIFO. It issues them to the datapath one at a time and decides when each command finishes: on `done_spin` for spin commands, or on a cycle-counted duration for drive commands. Between commands it drives a stop, applies a settle gap, and flags a fault if a spin never completes.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `TICK_DIV`, 1000: clock cycles per drive-duration unit.
- `GAP_CYCLES`, 4: stop/settle cycles between consecutive commands; minimum 1.
- `SPIN_TIMEOUT`, 1000000: maximum cycles in `RUN_SPIN` before fault; counter is 24 bits.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cmd_in`  in  10  command. [9] = command_type (1 spin, 0 drive), [8] = direction, [7:0] = angle (spin) or duration units (drive).
- `speed_in`  in  3  speed paired with `cmd_in`.
- `cmd_valid`  in  1  push request.
- `cmd_ready`  out  1  queue can accept.
- `abort`  in  1  synchronous flush and stop.
- `done_spin`  in  1  spin-complete level from the datapath.
- `motion_command`  out  10  registered, to the datapath.
- `input_speed`  out  3  registered, to the datapath.
- `cmd_done`  out  1  one-cycle pulse per completed command.
- `busy`  out  1  state != IDLE or queue non-empty.
- `fault`  out  1  sticky spin timeout.
- `queue_count`  out  log2(DEPTH)+1  occupancy.

## Operation
- **Reset values:** `motion_command`=0, `input_speed`=0, `cmd_done`=0, `busy`=0, `fault`=0, `queue_count`=0, `cmd_ready`=1, state IDLE.
- **Push:** accepted at a clock edge when `cmd_valid` && `cmd_ready`.
  - `cmd_ready` = (`queue_count` < DEPTH) && !`fault`. It is combinational from registered state.
  - When full, a push is refused even if a pop occurs in the same cycle.
- **Simultaneous push and pop:** `queue_count` is unchanged. FIFO order is preserved; read and write pointers wrap modulo DEPTH.
- **State machine:** IDLE, RUN_SPIN, RUN_DRIVE, SETTLE.
- **IDLE:** if the queue is non-empty, pop the head, load `motion_command`/`input_speed`, and go to RUN_SPIN ([9]=1) or RUN_DRIVE ([9]=0). Otherwise outputs stay 0.
- **RUN_SPIN:**
  - Completion is armed only after `done_spin` has been sampled 0 at least once in this state, so a stale high from the previous spin is ignored.
  - Once armed, `done_spin`=1 completes the command.
  - The timeout counter starts at 0 on entry and increments every cycle. When it reaches SPIN_TIMEOUT before completion:
    - `fault` is set and the queue is flushed;
    - outputs go to 0 and the state returns to IDLE;
    - no `cmd_done` pulse is generated.
- **RUN_DRIVE:**
  - For a duration of N ≥ 1, the state lasts exactly N×TICK_DIV cycles, using a prescaler counter plus a unit counter.
  - N=0 completes after 1 cycle.
- **Completion (spin or drive):** `motion_command`=0, `input_speed`=0, `cmd_done`=1 for one cycle, then SETTLE.
- **SETTLE:** holds outputs at 0 for GAP_CYCLES cycles, then returns to IDLE.
- **`abort`:** priority is below `rst` and above everything else.
  - Flushes the queue and sets outputs to 0.
  - Clears `fault` and sets the state to IDLE.
  - No `cmd_done` pulse; a push in the same cycle is dropped.
- **`fault`:** cleared only by `rst` or `abort`. While set, the queue stays empty and no pushes are accepted.

## Timing
- **Issue latency:** a push accepted at edge k into an empty queue while IDLE pops at edge k+1. `motion_command` is valid after edge k+1.
- **Back-to-back commands:** completion edge → `cmd_done` high for 1 cycle → 0 on outputs for GAP_CYCLES cycles → IDLE for 1 cycle → next command. The next command appears GAP_CYCLES+2 edges after the completion edge.
- **Spin completion:** sampled `done_spin` at edge j results in outputs at 0 and `cmd_done`=1 after edge j.
- **Drive duration N:** `motion_command` is non-zero for exactly N×TICK_DIV cycles (1 cycle if N=0).
- **Timeout:** `fault` rises after edge SPIN_TIMEOUT counted from RUN_SPIN entry.
- **Registered outputs:** all outputs except `cmd_ready` and `busy` are registered.

## Test plan
- **Reset then single drive:** reset; push 10'h005 (drive, N=5), speed 3, with TICK_DIV=4. Required: `motion_command`=10'h005 and `input_speed`=3 for exactly 20 cycles, then 0, one `cmd_done` pulse, and `busy` low after GAP_CYCLES+1 more cycles.
- **Spin with stale done:** hold `done_spin`=1, push 10'h35A (spin, dir 1, angle 0x5A). Required: no completion until `done_spin` goes 0 then 1; `cmd_done` follows the first sampled 1 after the arm.
- **Full queue:** push 5 commands back-to-back while stalled in a spin. Required: `queue_count` reaches 4, `cmd_ready`=0, the 5th push is dropped, and the 4 queued commands issue in FIFO order with the GAP_CYCLES spacing rule.
- **Spin timeout:** SPIN_TIMEOUT=50, `done_spin` held 0, 2 commands queued. Required: `fault`=1 after 50 cycles, queue flushed (`queue_count`=0), outputs 0, no `cmd_done`, `cmd_ready`=0. Then `abort` → `fault`=0, `cmd_ready`=1.
- **Abort mid-drive with simultaneous push:** assert `abort` together with `cmd_valid` during RUN_DRIVE. Required: next cycle outputs are 0, state IDLE, `queue_count`=0, no `cmd_done`, and the pushed command is not issued.
- **Zero-length drive and wrap-around:** push 10'h100 (drive, N=0), followed by 7 more commands to wrap the pointers. Required: a one-cycle issue for the N=0 command, and correct ordering across the pointer wrap.

Source files
------------

// File: rtl/motion_sequencer.sv
// Command queue and sequencer in front of the motion datapath: buffers commands,
// issues them one at a time, times drives, waits on done_spin for spins, and settles between.
module motion_sequencer #(
  parameter int DEPTH        = 4,
  parameter int TICK_DIV     = 1000,
  parameter int GAP_CYCLES   = 4,
  parameter int SPIN_TIMEOUT = 1000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [9:0]               cmd_in,
  input  logic [2:0]               speed_in,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     abort,
  input  logic                     done_spin,
  output logic [9:0]               motion_command,
  output logic [2:0]               input_speed,
  output logic                     cmd_done,
  output logic                     busy,
  output logic                     fault,
  output logic [$clog2(DEPTH):0]   queue_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES);
  localparam logic [23:0]   TMO_LAST = 24'(SPIN_TIMEOUT - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RUN_SPIN  = 2'd1,
    S_RUN_DRIVE = 2'd2,
    S_SETTLE    = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [12:0]     mem_q [DEPTH];
  logic [12:0]     mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [9:0]      cmd_q, cmd_d;
  logic [2:0]      speed_q, speed_d;
  logic            done_q, done_d;
  logic            fault_q, fault_d;
  logic            armed_q, armed_d;
  logic [23:0]     tmo_q, tmo_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [7:0]      unit_q, unit_d;
  logic [GW-1:0]   gap_q, gap_d;

  logic            push_s;
  logic            pop_s;
  logic            flush_s;
  logic            complete_s;
  logic [12:0]     head_s;

  assign cmd_ready      = (count_q < FULL_CNT) && !fault_q;
  assign busy           = (state_q != S_IDLE) || (count_q != {CW{1'b0}});
  assign motion_command = cmd_q;
  assign input_speed    = speed_q;
  assign cmd_done       = done_q;
  assign fault          = fault_q;
  assign queue_count    = count_q;

  // Next-state logic for the sequencer FSM, its timers and the FIFO pointers.
  always_comb begin
    state_d    = state_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    cmd_d      = cmd_q;
    speed_d    = speed_q;
    done_d     = 1'b0;
    fault_d    = fault_q;
    armed_d    = armed_q;
    tmo_d      = tmo_q;
    pre_d      = pre_q;
    unit_d     = unit_q;
    gap_d      = gap_q;
    pop_s      = 1'b0;
    flush_s    = 1'b0;
    complete_s = 1'b0;
    head_s     = mem_q[rd_ptr_q];
    push_s     = cmd_valid && cmd_ready;

    if (abort) begin
      flush_s = 1'b1;
      state_d = S_IDLE;
      cmd_d   = 10'd0;
      speed_d = 3'd0;
      fault_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (count_q != {CW{1'b0}}) begin
            pop_s   = 1'b1;
            cmd_d   = head_s[9:0];
            speed_d = head_s[12:10];
            armed_d = 1'b0;
            tmo_d   = 24'd0;
            pre_d   = {PW{1'b0}};
            unit_d  = head_s[7:0];
            state_d = head_s[9] ? S_RUN_SPIN : S_RUN_DRIVE;
          end else begin
            cmd_d   = 10'd0;
            speed_d = 3'd0;
          end
        end
        S_RUN_SPIN: begin
          // A done_spin still high from the previous spin must drop once before it counts.
          if (armed_q && done_spin) begin
            complete_s = 1'b1;
          end else if (tmo_q == TMO_LAST) begin
            fault_d = 1'b1;
            flush_s = 1'b1;
            cmd_d   = 10'd0;
            speed_d = 3'd0;
            state_d = S_IDLE;
          end else begin
            tmo_d   = tmo_q + 24'd1;
            armed_d = armed_q | ~done_spin;
          end
        end
        S_RUN_DRIVE: begin
          if ((unit_q == 8'd0) || ((pre_q == PRE_LAST) && (unit_q == 8'd1))) begin
            complete_s = 1'b1;
          end else if (pre_q == PRE_LAST) begin
            pre_d  = {PW{1'b0}};
            unit_d = unit_q - 8'd1;
          end else begin
            pre_d = pre_q + PW'(1);
          end
        end
        S_SETTLE: begin
          if (gap_q == GAP_LAST) begin
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cmd_d   = 10'd0;
          speed_d = 3'd0;
        end
      endcase
    end

    if (complete_s) begin
      cmd_d   = 10'd0;
      speed_d = 3'd0;
      done_d  = 1'b1;
      gap_d   = {GW{1'b0}};
      state_d = S_SETTLE;
    end else begin
      done_d = 1'b0;
    end

    if (flush_s) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = {speed_in, cmd_in};
      end else begin
        mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
      end
      wr_ptr_d = wr_ptr_q + AW'(push_s);
      rd_ptr_d = rd_ptr_q + AW'(pop_s);
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
      cmd_q    <= 10'd0;
      speed_q  <= 3'd0;
      done_q   <= 1'b0;
      fault_q  <= 1'b0;
      armed_q  <= 1'b0;
      tmo_q    <= 24'd0;
      pre_q    <= {PW{1'b0}};
      unit_q   <= 8'd0;
      gap_q    <= {GW{1'b0}};
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cmd_q    <= cmd_d;
      speed_q  <= speed_d;
      done_q   <= done_d;
      fault_q  <= fault_d;
      armed_q  <= armed_d;
      tmo_q    <= tmo_d;
      pre_q    <= pre_d;
      unit_q   <= unit_d;
      gap_q    <= gap_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_motion_sequencer.sv
// Self-checking bench for motion_sequencer: a scoreboard of expected issues is filled
// as commands are pushed and drained by a monitor that watches the datapath outputs.
module tb_motion_sequencer;

  localparam int DEPTH = 4;
  localparam int TICK  = 4;
  localparam int GAP   = 4;
  localparam int TMO   = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  cmd_in = 10'd0;
  logic [2:0]  speed_in = 3'd0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        abort = 1'b0;
  logic        done_spin = 1'b0;
  logic [9:0]  motion_command;
  logic [2:0]  input_speed;
  logic        cmd_done;
  logic        busy;
  logic        fault;
  logic [2:0]  queue_count;

  typedef struct packed {
    logic [9:0] cmd;
    logic [2:0] spd;
    logic       ok;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur = '0;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  int   run_len = 0;
  int   zero_len = 0;
  logic prev_end_ok = 1'b0;
  logic [9:0] prev_mc = 10'd0;

  motion_sequencer #(
    .DEPTH(DEPTH), .TICK_DIV(TICK), .GAP_CYCLES(GAP), .SPIN_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .cmd_in(cmd_in), .speed_in(speed_in),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
    .done_spin(done_spin), .motion_command(motion_command),
    .input_speed(input_speed), .cmd_done(cmd_done), .busy(busy),
    .fault(fault), .queue_count(queue_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Starts and ends at a falling edge; one accepted/refused push per call.
  task automatic push_cmd(input logic [9:0] c, input logic [2:0] s,
                          input logic exp_ready, input logic issue, input logic ok);
    exp_t e;
    cmd_in    = c;
    speed_in  = s;
    cmd_valid = 1'b1;
    check_val("push_ready", cmd_ready, exp_ready);
    if (exp_ready && issue) begin
      e.cmd = c; e.spd = s; e.ok = ok;
      exp_q.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic push_when_ready(input logic [9:0] c, input logic [2:0] s);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("ready_wait", cmd_ready, 1);
    push_cmd(c, s, 1'b1, 1'b1, 1'b1);
  endtask

  task automatic wait_mc(input string tag, input logic want_nz, input int budget);
    int n = 0;
    while (((motion_command != 10'd0) != want_nz) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, ((motion_command != 10'd0) == want_nz), 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, busy, 0);
  endtask

  // Scoreboard monitor: issue order, run length, completion pulse and inter-command gap.
  always @(negedge clk) begin
    if (cmd_done === 1'b1) done_cnt++;
    if (motion_command != 10'd0 && prev_mc == 10'd0) begin
      if (exp_q.size() == 0) begin
        check_val("issue_unexpected", motion_command, 0);
      end else begin
        cur = exp_q.pop_front();
        check_val("issue_cmd", motion_command, cur.cmd);
        check_val("issue_speed", input_speed, cur.spd);
        if (prev_end_ok) check_val("gap_len", zero_len, GAP + 2);
      end
      run_len = 1;
    end else if (motion_command != 10'd0) begin
      run_len++;
      check_val("run_hold", motion_command, cur.cmd);
    end else if (prev_mc != 10'd0) begin
      check_val("end_done", cmd_done, cur.ok);
      if (cur.ok && !cur.cmd[9])
        check_val("drive_len", run_len,
                  (cur.cmd[7:0] == 8'd0) ? 32'd1 : 32'(cur.cmd[7:0]) * TICK);
      prev_end_ok = cur.ok;
      zero_len = 1;
    end else begin
      zero_len++;
    end
    prev_mc = motion_command;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check_val("rst_mc", motion_command, 0);
    check_val("rst_speed", input_speed, 0);
    check_val("rst_done", cmd_done, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_fault", fault, 0);
    check_val("rst_count", queue_count, 0);
    check_val("rst_ready", cmd_ready, 1);
    rst = 1'b0;
    @(negedge clk);

    // Single drive N=5: 20 cycles, then settle
    prev_end_ok = 1'b0;
    push_cmd(10'h005, 3'd3, 1'b1, 1'b1, 1'b1);
    check_val("t1_count", queue_count, 1);
    check_val("t1_pre_issue", motion_command, 0);
    @(negedge clk);
    check_val("t1_issue_mc", motion_command, 10'h005);
    check_val("t1_issue_spd", input_speed, 3);
    wait_mc("t1_end_wait", 1'b0, 40);
    check_val("t1_done", cmd_done, 1);
    check_val("t1_busy_c", busy, 1);
    for (int i = 1; i <= GAP; i++) begin
      @(negedge clk);
      check_val("t1_busy_settle", busy, 1);
    end
    @(negedge clk);
    check_val("t1_busy_low", busy, 0);
    check_val("t1_done_cnt", done_cnt, 1);

    // Spin with stale done_spin high
    prev_end_ok = 1'b0;
    done_spin = 1'b1;
    push_cmd(10'h35A, 3'd5, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    check_val("t2_issue", motion_command, 10'h35A);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t2_stale_hold", motion_command, 10'h35A);
    end
    done_spin = 1'b0;
    @(negedge clk);
    check_val("t2_armed_hold", motion_command, 10'h35A);
    done_spin = 1'b1;
    @(negedge clk);
    check_val("t2_complete_mc", motion_command, 0);
    check_val("t2_complete_done", cmd_done, 1);
    done_spin = 1'b0;
    wait_idle("t2_idle", 50);
    check_val("t2_done_cnt", done_cnt, 2);

    // Full queue while stalled in a spin, then FIFO drain with gap spacing
    prev_end_ok = 1'b0;
    push_cmd(10'h211, 3'd1, 1'b1, 1'b1, 1'b1);
    push_cmd(10'h002, 3'd2, 1'b1, 1'b1, 1'b1);
    push_cmd(10'h101, 3'd4, 1'b1, 1'b1, 1'b1);
    push_cmd(10'h103, 3'd6, 1'b1, 1'b1, 1'b1);
    push_cmd(10'h001, 3'd7, 1'b1, 1'b1, 1'b1);
    check_val("t3_full_count", queue_count, 4);
    check_val("t3_full_ready", cmd_ready, 0);
    push_cmd(10'h0FF, 3'd1, 1'b0, 1'b0, 1'b0);
    check_val("t3_after_drop", queue_count, 4);
    done_spin = 1'b1;
    wait_idle("t3_idle", 300);
    done_spin = 1'b0;
    check_val("t3_sb_empty", exp_q.size(), 0);
    check_val("t3_done_cnt", done_cnt, 7);

    // Spin timeout with two queued commands
    prev_end_ok = 1'b0;
    push_cmd(10'h3C0, 3'd2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_val("t4_issue", motion_command, 10'h3C0);
    push_cmd(10'h004, 3'd1, 1'b1, 1'b0, 1'b0);
    push_cmd(10'h005, 3'd1, 1'b1, 1'b0, 1'b0);
    check_val("t4_queued", queue_count, 2);
    repeat (47) @(negedge clk);
    check_val("t4_fault_early", fault, 0);
    @(negedge clk);
    check_val("t4_fault", fault, 1);
    check_val("t4_flush", queue_count, 0);
    check_val("t4_mc", motion_command, 0);
    check_val("t4_speed", input_speed, 0);
    check_val("t4_no_done", cmd_done, 0);
    check_val("t4_ready", cmd_ready, 0);
    push_cmd(10'h006, 3'd1, 1'b0, 1'b0, 1'b0);
    check_val("t4_fault_push", queue_count, 0);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    check_val("t4_abort_fault", fault, 0);
    check_val("t4_abort_ready", cmd_ready, 1);
    check_val("t4_done_cnt", done_cnt, 7);

    // Abort mid-drive with a simultaneous push
    prev_end_ok = 1'b0;
    push_cmd(10'h00A, 3'd3, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_val("t5_issue", motion_command, 10'h00A);
    repeat (5) @(negedge clk);
    abort = 1'b1;
    cmd_valid = 1'b1;
    cmd_in = 10'h0AA;
    speed_in = 3'd2;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b0;
    cmd_valid = 1'b0;
    check_val("t5_mc", motion_command, 0);
    check_val("t5_speed", input_speed, 0);
    check_val("t5_count", queue_count, 0);
    check_val("t5_idle", busy, 0);
    check_val("t5_no_done", cmd_done, 0);
    repeat (3) @(negedge clk);
    check_val("t5_not_issued", motion_command, 0);
    check_val("t5_count_late", queue_count, 0);
    check_val("t5_done_cnt", done_cnt, 7);

    // Zero-length drives and pointer wrap
    prev_end_ok = 1'b0;
    push_when_ready(10'h100, 3'd1);
    push_when_ready(10'h001, 3'd2);
    push_when_ready(10'h102, 3'd3);
    push_when_ready(10'h100, 3'd4);
    push_when_ready(10'h001, 3'd5);
    push_when_ready(10'h101, 3'd6);
    push_when_ready(10'h002, 3'd7);
    push_when_ready(10'h100, 3'd0);
    wait_idle("t6_idle", 400);
    check_val("t6_sb_empty", exp_q.size(), 0);
    check_val("t6_done_cnt", done_cnt, 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
